// File: rtl/cpu_pkg.sv
// Shared types and constants for the 6502 branch sequencer.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EVAL  = 2'd2,
        FIX   = 2'd3
    } state_t;

    localparam int FLAG_N = 7;
    localparam int FLAG_V = 6;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    // cond_sel is opcode[7:6] of the branch instruction
    typedef enum logic [1:0] {
        COND_N = 2'b00,
        COND_V = 2'b01,
        COND_C = 2'b10,
        COND_Z = 2'b11
    } cond_sel_t;

endpackage

// File: rtl/branch_cond.sv
// Branch condition: pick one status flag and compare it with the required value.
module branch_cond
    import cpu_pkg::*;
(
    input  logic [1:0] i_cond_sel,
    input  logic       i_cond_val,
    input  logic [7:0] i_p_flags,
    output logic       o_taken
);

    logic w_flag;

    always_comb begin
        w_flag = 1'b0;
        case (cond_sel_t'(i_cond_sel))
            COND_N:  w_flag = i_p_flags[FLAG_N];
            COND_V:  w_flag = i_p_flags[FLAG_V];
            COND_C:  w_flag = i_p_flags[FLAG_C];
            COND_Z:  w_flag = i_p_flags[FLAG_Z];
            default: w_flag = 1'b0;
        endcase
        o_taken = (w_flag == i_cond_val);
    end

endmodule

// File: rtl/branch_ctrl.sv
// 6502 relative-branch sequencer driving the PC register's load/increment controls.
//   state | meaning
//   IDLE  | waiting for start; condition latched on start
//   FETCH | waiting for the offset operand; l_inc when it arrives
//   EVAL  | PC is next-instruction address; load PCL with PCL+offset if taken
//   FIX   | page crossing repair: h_inc forward, PCH-1 backward
module branch_ctrl
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] cond_sel,
    input  logic       cond_val,
    input  logic [7:0] p_flags,
    input  logic [7:0] offset_in,
    input  logic       offset_valid,
    input  logic [7:0] pcl_cur,
    input  logic [7:0] pch_cur,
    output logic [7:0] pcl_new,
    output logic [7:0] pch_new,
    output logic       load_pc_l,
    output logic       load_pc_h,
    output logic       l_inc,
    output logic       h_inc,
    output logic       busy,
    output logic       done,
    output logic       taken,
    output logic       page_cross
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_cond;
    logic [7:0] r_offset;
    logic       r_bwd;
    logic       r_done;
    logic       r_page;

    logic       w_cond;
    logic [8:0] w_sum9;
    logic       w_fwd_cross;
    logic       w_bwd_cross;
    logic       w_l_inc, w_load_l, w_load_h, w_h_inc;
    logic [7:0] w_pcl, w_pch;
    logic       w_busy, w_done_nt, w_done_set, w_page_set;

    branch_cond u_cond (
        .i_cond_sel (cond_sel),
        .i_cond_val (cond_val),
        .i_p_flags  (p_flags),
        .o_taken    (w_cond)
    );

    assign w_sum9      = {1'b0, pcl_cur} + {1'b0, r_offset};
    assign w_fwd_cross = ~r_offset[7] &  w_sum9[8];
    assign w_bwd_cross =  r_offset[7] & ~w_sum9[8];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cond   <= 1'b0;
            r_offset <= 8'h00;
            r_bwd    <= 1'b0;
            r_done   <= 1'b0;
            r_page   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_set;
            r_page  <= w_page_set;
            if (r_state == IDLE && start)
                r_cond <= w_cond;
            if (r_state == FETCH && offset_valid)
                r_offset <= offset_in;
            if (r_state == EVAL)
                r_bwd <= w_bwd_cross;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_l_inc     = 1'b0;
        w_load_l    = 1'b0;
        w_load_h    = 1'b0;
        w_h_inc     = 1'b0;
        w_pcl       = 8'h00;
        w_pch       = 8'h00;
        w_busy      = 1'b1;
        w_done_nt   = 1'b0;
        w_done_set  = 1'b0;
        w_page_set  = 1'b0;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (start)
                    w_state_nxt = FETCH;
            end
            FETCH: begin
                if (offset_valid) begin
                    w_l_inc     = 1'b1;
                    w_state_nxt = EVAL;
                end
            end
            EVAL: begin
                if (!r_cond) begin
                    w_done_nt   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_load_l = 1'b1;
                    w_pcl    = w_sum9[7:0];
                    if (w_fwd_cross || w_bwd_cross) begin
                        w_state_nxt = FIX;
                    end else begin
                        w_done_set  = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            FIX: begin
                if (r_bwd) begin
                    w_load_h = 1'b1;
                    w_pch    = pch_cur - 8'd1;
                end else begin
                    w_h_inc = 1'b1;
                end
                w_done_set  = 1'b1;
                w_page_set  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are forced low while reset is held so an abandoned branch never touches the PC.
    assign l_inc      = rst_n & w_l_inc;
    assign load_pc_l  = rst_n & w_load_l;
    assign load_pc_h  = rst_n & w_load_h;
    assign h_inc      = rst_n & w_h_inc;
    assign pcl_new    = rst_n ? w_pcl : 8'h00;
    assign pch_new    = rst_n ? w_pch : 8'h00;
    assign busy       = rst_n & w_busy;
    assign done       = rst_n & (w_done_nt | r_done);
    assign taken      = rst_n & r_done;
    assign page_cross = rst_n & r_page;

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Sequencer for 6502 relative branches (BPL/BMI/BVC/BVS/BCC/BCS/BNE/BEQ).
- Sits directly upstream of the 16-bit PC register.
  - Reads the PC register's PCL/PCH outputs.
  - Drives its load_pc_l, load_pc_h, L_inc and H_inc controls and its PCL_in/PCH_in data.
- Evaluates the branch condition, adds the signed offset to PCL, and repairs the page crossing.
  - Forward crossing: H_inc.
  - Backward crossing: PCH-1 via load_pc_h.
- Reproduces NMOS timing: 2 cycles not taken, 3 taken, 4 taken with page cross.

Parameters:
- None. Widths are fixed by the architecture: 8-bit data, 16-bit PC.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- start  in  1  one-cycle pulse: branch opcode decoded, PC points at the offset operand.
- cond_sel  in  2  flag select, equal to opcode[7:6]: 00=N(P[7]), 01=V(P[6]), 10=C(P[0]), 11=Z(P[1]).
- cond_val  in  1  required flag value for taken, equal to opcode[5].
- p_flags  in  8  processor status register.
- offset_in  in  8  operand byte from the data bus, two's complement.
- offset_valid  in  1  offset_in valid this cycle; low means memory stall.
- pcl_cur  in  8  PC register PCL_out.
- pch_cur  in  8  PC register PCH_out.
- pcl_new  out  8  to PC register PCL_in.
- pch_new  out  8  to PC register PCH_in.
- load_pc_l  out  1  to PC register.
- load_pc_h  out  1  to PC register.
- l_inc  out  1  to PC register L_inc.
- h_inc  out  1  to PC register H_inc.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse, branch complete.
- taken  out  1  valid with done: condition was met.
- page_cross  out  1  valid with done: page fixup was performed.

Behaviour:
- Reset (rst_n low at posedge):
  - State goes to IDLE.
  - All outputs are 0, including pcl_new/pch_new.
  - Internal offset, direction and sum registers are cleared.
  - Reset mid-branch abandons the branch immediately; no load, inc or done follows.
- IDLE:
  - start=1 → FETCH.
  - Condition is evaluated and latched at start; p_flags are ignored afterwards.
- FETCH:
  - Hold while offset_valid=0.
  - When offset_valid=1: latch offset_in, assert l_inc this cycle (PC advances past the operand), go to EVAL.
- EVAL (PC now equals the next-instruction address):
  - Not taken: done=1, taken=0 → IDLE.
  - Taken:
    - sum9 = {0,pcl_cur} + {0,offset}; pcl_new = sum9[7:0]; assert load_pc_l.
    - fwd_cross = ~offset[7] & sum9[8]; bwd_cross = offset[7] & ~sum9[8].
    - If either crossing: latch direction → FIX.
    - Otherwise: done=1, taken=1 → IDLE.
  - The combined assert-and-transition is registered, so done appears at the EVAL cycle boundary.
- FIX:
  - Forward crossing: assert h_inc.
  - Backward crossing: pch_new = pch_cur - 1 (mod 256), assert load_pc_h.
  - Then done=1, taken=1, page_cross=1 → IDLE.
- Cycle counts from the start cycle:
  - Not taken: done 2 cycles later.
  - Taken: done 3 cycles later.
  - Taken with crossing: done 4 cycles later.
  - Add one cycle per stall cycle.
- Control outputs:
  - All control outputs are combinational from state plus registered data.
  - Only one of l_inc, load_pc_l, h_inc, load_pc_h is high in any cycle.
- Wrap-around:
  - Forward cross from PCH=FF goes to 00 (the PC register's H_inc wraps).
  - Backward cross from PCH=00 goes to FF.
- start while busy is ignored; there is no queueing.
- done, taken and page_cross hold 0 except during the done cycle.
- Offset 0x00 taken: PC unchanged, 3 cycles.
- Offset 0x80 (-128): handled as negative.

Decomposition:
- Shared package (cpu_pkg):
  - State enum {IDLE, FETCH, EVAL, FIX}.
  - Flag bit index constants: FLAG_N=7, FLAG_V=6, FLAG_Z=1, FLAG_C=0.
  - cond_sel encodings.
- One natural sub-module, branch_cond: combinational select of p_flags by cond_sel, compare to cond_val.
- The adder and crossing logic stay inline.

Test Plan:
- BNE with Z=1, PC=0x1233 at start, offset 0x10:
  - l_inc in FETCH; done+taken=0 two cycles after start.
  - No load or h_inc; PC=0x1234.
- BEQ with Z=1, PC after operand 0x1234, offset 0x10:
  - load_pc_l with pcl_new=0x44; done three cycles after start, page_cross=0.
  - PC=0x1244.
- BCS with C=1, PC 0x12F0, offset 0x20:
  - EVAL loads PCL=0x10; FIX asserts h_inc.
  - PC=0x1310, page_cross=1, 4 cycles.
- BMI with N=1, PC 0x1205, offset 0xF0:
  - EVAL loads 0xF5; FIX load_pc_h with pch_new=0x11.
  - PC=0x11F5.
- Taken, PC 0x1234, offset 0xFE: PC=0x1232, no FIX.
- Taken with crossing from 0xFFF0, offset 0x20: PC=0x0010.
- offset_valid held low 3 cycles in FETCH: busy stays high, no controls asserted, done delayed exactly 3 cycles.
- Stimulus during an active branch:
  - start pulsed in EVAL: ignored.
  - rst_n low in FIX: next cycle IDLE, all outputs 0, no h_inc and no done.
